// File: rtl/ser_pkg.sv
// Shared types and default sizes for the serial-to-parallel deserializer.
package ser_pkg;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   typedef enum logic {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } ser_state_t;

   // One completed word: left-aligned data plus the number of bits received.
   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [CNT_W-1:0] mod;
   } ser_word_t;

endpackage

// File: rtl/ser_deserializer_if.sv
// Serial input, parallel valid/ready output and status of the deserializer.
interface ser_deserializer_if #(
   parameter int WIDTH = ser_pkg::WIDTH,
   parameter int CNT_W = ser_pkg::CNT_W
);

   logic             ser_data_i;
   logic             ser_data_val_i;
   logic [WIDTH-1:0] data_o;
   logic [CNT_W-1:0] data_mod_o;
   logic             data_val_o;
   logic             data_rdy_i;
   logic             busy_o;
   logic             overflow_o;

   // Deserializer side.
   modport slave (
      input  ser_data_i,
      input  ser_data_val_i,
      input  data_rdy_i,
      output data_o,
      output data_mod_o,
      output data_val_o,
      output busy_o,
      output overflow_o
   );

   // Upstream serializer / downstream consumer side.
   modport master (
      output ser_data_i,
      output ser_data_val_i,
      output data_rdy_i,
      input  data_o,
      input  data_mod_o,
      input  data_val_o,
      input  busy_o,
      input  overflow_o
   );

endinterface

// File: rtl/ser_word_fifo.sv
// Small synchronous FIFO of completed words. Pointers carry one extra wrap bit
// so full and empty can be told apart without a separate occupancy counter.
module ser_word_fifo
   import ser_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push,
   input  ser_word_t push_word,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output ser_word_t head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   ser_word_t   mem [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A push into a full FIFO only lands when the head leaves on the same edge;
   // the freed slot is exactly the one the write pointer addresses.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign head = mem[rd_ptr[AW-1:0]];

   // Storage and pointer update.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ser_deserializer.sv
// Reassembles MSB-first serial bursts into left-aligned words with a bit
// count, buffers them and presents them on a valid/ready interface.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  IDLE    | no word in progress; next valid bit starts a new word
//  COLLECT | shifting bits of the current burst into sr, cnt bits so far
module ser_deserializer
#(
   parameter int WIDTH = ser_pkg::WIDTH,
   parameter int DEPTH = 4,
   parameter int CNT_W = ser_pkg::CNT_W
) (
   input  logic                clk_i,
   input  logic                rst_i,
   ser_deserializer_if.slave   bus
);

   import ser_pkg::*;

   ser_state_t       state;
   logic [WIDTH-1:0] sr;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             overflow;

   logic [WIDTH-1:0] new_sr;
   logic [CNT_W-1:0] new_cnt;
   logic             last_bit;
   logic             push;
   ser_word_t        push_word;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   ser_word_t        head;

   // Shift register and count as they would look after accepting this bit.
   always_comb begin
      new_sr  = sr;
      new_cnt = cnt;
      if (state == IDLE) begin
         new_sr            = '0;
         new_sr[WIDTH-1]   = bus.ser_data_i;
         new_cnt           = CNT_W'(1);
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1 - int'(cnt)) begin
               new_sr[i] = bus.ser_data_i;
            end
         end
         new_cnt = cnt + CNT_W'(1);
      end
   end

   // A word completes either when valid drops during a burst or when the
   // WIDTH-th bit arrives; in the latter case the incoming bit is included.
   always_comb begin
      last_bit       = bus.ser_data_val_i && (new_cnt == CNT_W'(WIDTH));
      push           = ((state == COLLECT) && !bus.ser_data_val_i) || last_bit;
      push_word.data = bus.ser_data_val_i ? new_sr  : sr;
      push_word.mod  = bus.ser_data_val_i ? new_cnt : cnt;
   end

   assign pop = !fifo_empty && bus.data_rdy_i;

   // Burst FSM with registered busy and sticky overflow.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         sr       <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (bus.ser_data_val_i) begin
                  sr  <= new_sr;
                  cnt <= new_cnt;
                  if (last_bit) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= COLLECT;
                     busy  <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (bus.ser_data_val_i) begin
                  sr  <= new_sr;
                  cnt <= new_cnt;
                  if (last_bit) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   ser_word_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push      (push),
      .push_word (push_word),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (head)
   );

   assign bus.data_o     = head.data;
   assign bus.data_mod_o = head.mod;
   assign bus.data_val_o = !fifo_empty;
   assign bus.busy_o     = busy;
   assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_ser_deserializer.sv
// Directed bench for the deserializer: a vector table of single bursts plus
// hand-written sequences for back-to-back words, overflow, and reset.
module tb_ser_deserializer;

   logic clk;
   logic rst;

   ser_deserializer_if #(.WIDTH(16), .CNT_W(5)) bus ();

   ser_deserializer #(
      .WIDTH (16),
      .DEPTH (4),
      .CNT_W (5)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      int          len;
      logic [31:0] bits;
      logic [15:0] exp_data;
      logic [4:0]  exp_mod;
   } vec_t;

   typedef struct packed {
      logic [15:0] data;
      logic [4:0]  mod;
   } obs_t;

   int   errors;
   int   checks;
   int   busy_cnt;
   obs_t mon_q[$];
   vec_t vecs[8];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Record every word accepted by the consumer.
   always @(negedge clk) begin
      if (!rst && bus.data_val_o && bus.data_rdy_i) begin
         mon_q.push_back({bus.data_o, bus.data_mod_o});
      end
      if (bus.busy_o) begin
         busy_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // MSB-first burst of len bits from the right-aligned value, then valid low.
   task automatic send_burst(input int len, input logic [31:0] bits);
      for (int i = 0; i < len; i++) begin
         tick();
         bus.ser_data_val_i = 1'b1;
         bus.ser_data_i     = bits[len-1-i];
      end
      tick();
      bus.ser_data_val_i = 1'b0;
      bus.ser_data_i     = 1'b1;
   endtask

   task automatic check_q(input string name, input int k, input logic [15:0] d, input logic [4:0] m);
      obs_t o;
      o = (k < mon_q.size()) ? mon_q[k] : '0;
      check({name, "_data"}, 32'(o.data), 32'(d));
      check({name, "_mod"},  32'(o.mod),  32'(m));
   endtask

   initial begin
      errors = 0;
      checks = 0;
      busy_cnt = 0;
      rst = 1'b0;
      bus.ser_data_i     = 1'b0;
      bus.ser_data_val_i = 1'b0;
      bus.data_rdy_i     = 1'b0;

      vecs[0] = '{4,  32'hA,    16'hA000, 5'd4};
      vecs[1] = '{3,  32'h3,    16'h6000, 5'd3};
      vecs[2] = '{1,  32'h0,    16'h0000, 5'd1};
      vecs[3] = '{7,  32'h7F,   16'hFE00, 5'd7};
      vecs[4] = '{8,  32'h81,   16'h8100, 5'd8};
      vecs[5] = '{15, 32'h7FFF, 16'hFFFE, 5'd15};
      vecs[6] = '{16, 32'hA5A5, 16'hA5A5, 5'd16};
      vecs[7] = '{12, 32'hABC,  16'hABC0, 5'd12};

      // Reset state
      #1 rst = 1'b1;
      #2;
      check("rst_data",  32'(bus.data_o),     32'h0);
      check("rst_mod",   32'(bus.data_mod_o), 32'h0);
      check("rst_val",   32'(bus.data_val_o), 32'h0);
      check("rst_busy",  32'(bus.busy_o),     32'h0);
      check("rst_ovf",   32'(bus.overflow_o), 32'h0);
      tick();
      rst = 1'b0;

      // 4-bit burst 1010: latency and busy width
      busy_cnt = 0;
      send_burst(4, 32'hA);
      check("t1_val_early", 32'(bus.data_val_o), 32'h0);
      tick();
      check("t1_val",  32'(bus.data_val_o), 32'h1);
      check("t1_data", 32'(bus.data_o),     32'hA000);
      check("t1_mod",  32'(bus.data_mod_o), 32'h4);
      tick();
      tick();
      check("t1_busy_cycles", 32'(busy_cnt), 32'd4);
      bus.data_rdy_i = 1'b1;
      tick();
      bus.data_rdy_i = 1'b0;
      check("t1_val_after_pop", 32'(bus.data_val_o), 32'h0);

      // Vector table: one burst, inspect head, pop it
      for (int v = 0; v < 8; v++) begin
         send_burst(vecs[v].len, vecs[v].bits);
         tick();
         tick();
         check($sformatf("vec%0d_val", v),  32'(bus.data_val_o), 32'h1);
         check($sformatf("vec%0d_data", v), 32'(bus.data_o),     32'(vecs[v].exp_data));
         check($sformatf("vec%0d_mod", v),  32'(bus.data_mod_o), 32'(vecs[v].exp_mod));
         bus.data_rdy_i = 1'b1;
         tick();
         bus.data_rdy_i = 1'b0;
         check($sformatf("vec%0d_empty", v), 32'(bus.data_val_o), 32'h0);
      end

      // 20 continuous bits: full word then a 4-bit word with no gap
      mon_q.delete();
      bus.data_rdy_i = 1'b1;
      send_burst(20, 32'hA5A5C);
      repeat (4) tick();
      bus.data_rdy_i = 1'b0;
      check("t2_count", 32'(mon_q.size()), 32'd2);
      check_q("t2_w0", 0, 16'hA5A5, 5'd16);
      check_q("t2_w1", 1, 16'hC000, 5'd4);

      // Five 1-bit words into a 4-deep FIFO with no consumer
      for (int k = 0; k < 5; k++) begin
         send_burst(1, 32'h1);
      end
      tick();
      tick();
      check("t3_val", 32'(bus.data_val_o), 32'h1);
      check("t3_ovf", 32'(bus.overflow_o), 32'h1);
      mon_q.delete();
      bus.data_rdy_i = 1'b1;
      repeat (6) tick();
      bus.data_rdy_i = 1'b0;
      check("t3_count", 32'(mon_q.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         check_q($sformatf("t3_w%0d", k), k, 16'h8000, 5'd1);
      end
      check("t3_empty", 32'(bus.data_val_o), 32'h0);
      check("t3_ovf_sticky", 32'(bus.overflow_o), 32'h1);

      // Full FIFO, push and pop on the same edge
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mon_q.delete();
      send_burst(1, 32'h1);
      send_burst(2, 32'h1);
      send_burst(3, 32'h1);
      send_burst(4, 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.ser_data_val_i = 1'b1;
         bus.ser_data_i     = 1'b1;
      end
      tick();
      bus.ser_data_val_i = 1'b0;
      bus.data_rdy_i     = 1'b1;
      tick();
      bus.data_rdy_i     = 1'b0;
      check("t4_ovf_none", 32'(bus.overflow_o), 32'h0);
      check("t4_val",      32'(bus.data_val_o), 32'h1);
      send_burst(1, 32'h0);
      tick();
      check("t4_still_full", 32'(bus.overflow_o), 32'h1);
      bus.data_rdy_i = 1'b1;
      repeat (6) tick();
      bus.data_rdy_i = 1'b0;
      check("t4_count", 32'(mon_q.size()), 32'd5);
      check_q("t4_w0", 0, 16'h8000, 5'd1);
      check_q("t4_w1", 1, 16'h4000, 5'd2);
      check_q("t4_w2", 2, 16'h2000, 5'd3);
      check_q("t4_w3", 3, 16'h1000, 5'd4);
      check_q("t4_w4", 4, 16'hF800, 5'd5);

      // Asynchronous reset in the middle of a burst
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      bus.ser_data_val_i = 1'b1;
      bus.ser_data_i     = 1'b1;
      tick();
      bus.ser_data_i     = 1'b0;
      tick();
      bus.ser_data_i     = 1'b1;
      tick();
      check("t5_busy_before", 32'(bus.busy_o), 32'h1);
      #2;
      rst = 1'b1;
      bus.ser_data_val_i = 1'b0;
      #1;
      check("t5_busy",  32'(bus.busy_o),     32'h0);
      check("t5_val",   32'(bus.data_val_o), 32'h0);
      check("t5_data",  32'(bus.data_o),     32'h0);
      check("t5_mod",   32'(bus.data_mod_o), 32'h0);
      check("t5_ovf",   32'(bus.overflow_o), 32'h0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("t5_no_word", 32'(bus.data_val_o), 32'h0);
      send_burst(2, 32'h1);
      tick();
      check("t5_next_val",  32'(bus.data_val_o), 32'h1);
      check("t5_next_data", 32'(bus.data_o),     32'h4000);
      check("t5_next_mod",  32'(bus.data_mod_o), 32'h2);
      bus.data_rdy_i = 1'b1;
      tick();
      bus.data_rdy_i = 1'b0;

      // Two 1-bit words, 0 then 1, one idle cycle apart
      mon_q.delete();
      bus.data_rdy_i = 1'b1;
      send_burst(1, 32'h0);
      send_burst(1, 32'h1);
      repeat (3) tick();
      bus.data_rdy_i = 1'b0;
      check("t6_count", 32'(mon_q.size()), 32'd2);
      check_q("t6_w0", 0, 16'h0000, 5'd1);
      check_q("t6_w1", 1, 16'h8000, 5'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
